// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, runs a request/ack instruction
// memory port and buffers one word for the IF/ID register, with redirect support.
module if_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        switch_mode,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        if_request,
    output logic [63:0] if_address,
    input  logic        if_ack,
    input  logic [31:0] if_data,
    output logic [63:0] pc_if,
    output logic [31:0] inst,
    output logic        if_valid,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_VALID = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [63:0] pc_reg, pc_next;
    logic [63:0] tgt_reg, tgt_next;
    logic [31:0] inst_buf_reg, inst_buf_next;

    logic        redir;
    logic [63:0] redir_target;
    logic        unused_rpc_bits;

    assign redir           = redirect | switch_mode;
    assign redir_target    = switch_mode ? RESET_PC : {redirect_pc[63:2], 2'b00};
    assign unused_rpc_bits = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_REQ;
            pc_reg       <= RESET_PC;
            tgt_reg      <= RESET_PC;
            inst_buf_reg <= NOP_INST;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            tgt_reg      <= tgt_next;
            inst_buf_reg <= inst_buf_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        tgt_next      = tgt_reg;
        inst_buf_next = inst_buf_reg;
        case (state_reg)
            S_REQ: begin
                if (redir) begin
                    // An ack arriving with the redirect closes the transaction,
                    // so the new target can be fetched without draining.
                    if (if_ack) begin
                        pc_next = redir_target;
                    end else begin
                        tgt_next   = redir_target;
                        state_next = S_DRAIN;
                    end
                end else if (if_ack) begin
                    inst_buf_next = if_data;
                    state_next    = S_VALID;
                end
            end
            S_VALID: begin
                if (redir) begin
                    pc_next    = redir_target;
                    state_next = S_REQ;
                end else if (!stall) begin
                    pc_next    = pc_reg + 64'd4;
                    state_next = S_REQ;
                end
            end
            S_DRAIN: begin
                if (redir) begin
                    tgt_next = redir_target;
                end
                if (if_ack) begin
                    pc_next    = redir ? redir_target : tgt_reg;
                    state_next = S_REQ;
                end
            end
            default: begin
                state_next = S_REQ;
            end
        endcase
    end

    // Request is decoded from registered state only; reset withdraws it at once.
    assign if_request = (state_reg != S_VALID) && !rst;
    assign if_address = pc_reg;
    assign if_valid   = (state_reg == S_VALID);
    assign fetch_busy = (state_reg != S_VALID);
    assign pc_if      = pc_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_inst_lane
            assign inst[gi*8 +: 8] = if_valid ? inst_buf_reg[gi*8 +: 8]
                                              : NOP_INST[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: latency-configurable memory responder, fetch model
// and a scoreboard of accepted words checked when they appear on the ID side.
module tb_if_fetch_unit;

    localparam logic [63:0] RESET_PC = 64'h1000;
    localparam logic [31:0] NOP_INST = 32'h00000013;
    localparam int ST_REQ = 0, ST_VALID = 1, ST_DRAIN = 2;

    logic        clk = 1'b0;
    logic        rst, switch_mode, stall, redirect;
    logic [63:0] redirect_pc;
    logic        if_request, if_ack, if_valid, fetch_busy;
    logic [63:0] if_address, pc_if;
    logic [31:0] if_data, inst;

    if_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk(clk), .rst(rst), .switch_mode(switch_mode), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .if_request(if_request), .if_address(if_address),
        .if_ack(if_ack), .if_data(if_data),
        .pc_if(pc_if), .inst(inst), .if_valid(if_valid), .fetch_busy(fetch_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] word;
    } ent_t;

    ent_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;

    int          m_state;
    logic [63:0] m_pc, m_tgt;
    logic [31:0] m_inst;
    logic        m_fresh;
    int          wait_cnt;
    int          lat;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h1004) return 32'h00500093;
        return a[31:0] ^ 32'h5A5A0013;
    endfunction

    // One clock cycle: drive inputs and memory response, check outputs, advance model.
    task automatic cyc(input logic st, input logic rd, input logic [63:0] rpc,
                       input logic sw, input logic r);
        logic        req_exp, ack_v, red;
        logic [31:0] dat;
        logic [63:0] t;
        ent_t        e;
        @(negedge clk);
        req_exp = (m_state != ST_VALID) && !r;
        ack_v   = req_exp && (wait_cnt >= lat);
        dat     = mem_word(m_pc);
        rst = r; stall = st; redirect = rd; redirect_pc = rpc; switch_mode = sw;
        if_ack  = ack_v;
        if_data = ack_v ? dat : 32'hDEADBEEF;
        #1;
        check_val("if_request", {63'd0, if_request}, {63'd0, req_exp});
        if (req_exp) check_val("if_address", if_address, m_pc);
        check_val("if_valid", {63'd0, if_valid}, {63'd0, m_state == ST_VALID});
        check_val("fetch_busy", {63'd0, fetch_busy}, {63'd0, m_state != ST_VALID});
        check_val("pc_if", pc_if, m_pc);
        if (m_state == ST_VALID) begin
            if (m_fresh) begin
                m_fresh = 1'b0;
                if (sb.size() == 0) begin
                    check_val("sb_underflow", 64'd1, {63'd0, if_valid ^ 1'b1});
                end else begin
                    e = sb.pop_front();
                    m_inst = e.word;
                    $display("fetch pc=%h inst=%h (dut pc_if=%h inst=%h)", e.pc, e.word, pc_if, inst);
                    check_val("sb_pc", pc_if, e.pc);
                end
            end
            check_val("inst", {32'd0, inst}, {32'd0, m_inst});
        end else begin
            check_val("inst_nop", {32'd0, inst}, {32'd0, NOP_INST});
        end

        red = rd | sw;
        t   = sw ? RESET_PC : {rpc[63:2], 2'b00};
        if (r) begin
            m_state = ST_REQ; m_pc = RESET_PC; m_fresh = 1'b0;
        end else begin
            case (m_state)
                ST_REQ: begin
                    if (red) begin
                        if (ack_v) m_pc = t;
                        else begin m_tgt = t; m_state = ST_DRAIN; end
                    end else if (ack_v) begin
                        e.pc = m_pc; e.word = dat;
                        sb.push_back(e);
                        m_state = ST_VALID; m_fresh = 1'b1;
                    end
                end
                ST_VALID: begin
                    if (red) begin m_pc = t; m_state = ST_REQ; end
                    else if (!st) begin m_pc = m_pc + 64'd4; m_state = ST_REQ; end
                end
                default: begin
                    if (red) m_tgt = t;
                    if (ack_v) begin m_pc = m_tgt; m_state = ST_REQ; end
                end
            endcase
        end
        if (r || !req_exp || ack_v) wait_cnt = 0;
        else wait_cnt++;
    endtask

    // Idle cycles until the model's upcoming cycle is in state st (and wait count cnt in REQ).
    task automatic go_until(input int st, input int cnt);
        int g = 0;
        while (!(m_state == st && (st != ST_REQ || wait_cnt == cnt)) && g < 100) begin
            cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
            g++;
        end
        check_val("go_until_state", m_state, st);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; switch_mode = 1'b0; stall = 1'b0; redirect = 1'b0;
        redirect_pc = 64'd0; if_ack = 1'b0; if_data = 32'd0;
        lat = 0; wait_cnt = 0;
        m_state = ST_REQ; m_pc = RESET_PC; m_tgt = RESET_PC; m_inst = NOP_INST; m_fresh = 1'b0;
        repeat (2) @(posedge clk);

        // Reset values while rst is still high
        cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        check_val("rst_request", {63'd0, if_request}, 64'd0);
        check_val("rst_pc_if", pc_if, RESET_PC);

        // Zero-wait streaming then stall in VALID at 0x1004
        cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        check_val("first_addr", if_address, 64'h1000);
        cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
            check_val("stall_inst", {32'd0, inst}, 64'h00500093);
            check_val("stall_pc_if", pc_if, 64'h1004);
            check_val("stall_no_req", {63'd0, if_request}, 64'd0);
        end
        cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        check_val("after_stall_addr", if_address, 64'h1008);
        idle(6);

        // Redirect in the second wait cycle of a slow fetch
        lat = 3;
        go_until(ST_REQ, 1);
        cyc(1'b0, 1'b1, 64'h2000, 1'b0, 1'b0);
        go_until(ST_REQ, 0);
        cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        check_val("drain_resume", if_address, 64'h2000);
        idle(10);

        // Redirect coincident with ack in REQ
        lat = 0;
        go_until(ST_REQ, 0);
        cyc(1'b0, 1'b1, 64'h3000, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        check_val("redir_ack_addr", if_address, 64'h3000);
        idle(5);

        // Two redirects during DRAIN: the last one wins
        lat = 3;
        go_until(ST_REQ, 0);
        cyc(1'b0, 1'b1, 64'h4000, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 64'h5000, 1'b0, 1'b0);
        go_until(ST_REQ, 0);
        cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        check_val("double_redir", if_address, 64'h5000);
        idle(6);

        // Mode switch in VALID beats stall
        lat = 0;
        go_until(ST_VALID, 0);
        cyc(1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        check_val("switch_valid", {63'd0, if_valid}, 64'd0);
        check_val("switch_addr", if_address, RESET_PC);
        idle(4);

        // Reset in the middle of an outstanding request
        lat = 3;
        go_until(ST_REQ, 1);
        cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        check_val("rst_mid_addr", if_address, RESET_PC);
        check_val("rst_mid_inst", {32'd0, inst}, {32'd0, NOP_INST});
        check_val("rst_mid_busy", {63'd0, fetch_busy}, 64'd1);
        idle(8);

        // PC wrap at the top of the address space, with low target bits masked
        lat = 1;
        go_until(ST_REQ, 0);
        cyc(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        go_until(ST_VALID, 0);
        cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        check_val("wrap_pc_if", pc_if, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        check_val("wrap_addr", if_address, 64'h0);
        idle(6);

        check_val("sb_leftover", sb.size(), (m_state == ST_VALID && m_fresh) ? 64'd1 : 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
